// File: rtl/prim_clock_gate_ctrl.sv
// Purpose: idle-driven clock-gate enable controller (ON -> WAIT_IDLE -> OFF -> WAKE -> ON).
// Latency: all outputs are flops loaded from next state; en_o changes on the edge the FSM enters/leaves OFF.
// Backpressure: none; req_en_i aborts gating immediately from WAIT_IDLE, is ignored during WAKE.
module prim_clock_gate_ctrl #(
  parameter int unsigned IdleCycles = 4,
  parameter int unsigned WakeCycles = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_en_i,
  input  logic idle_i,
  output logic en_o,
  output logic status_o,
  output logic busy_o
);

  // Terminal counter values; legal parameter range 1..255 keeps these within 8 bits.
  localparam logic [7:0] IdleLast = 8'(IdleCycles - 1);
  localparam logic [7:0] WakeLast = 8'(WakeCycles - 1);
  localparam logic [7:0] CntMax   = 8'hFF;

  typedef enum logic [1:0] {
    ST_ON        = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_OFF       = 2'd2,
    ST_WAKE      = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic [7:0] wake_cnt_q, wake_cnt_d;
  logic       en_d, status_d, busy_d;

  // Next-state and counter update; counters clear whenever a new state is entered.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;

    unique case (state_q)
      ST_ON: begin
        // Dropping the request never gates directly: idle must be proven first.
        if (!req_en_i) begin
          state_d = ST_WAIT_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        if (req_en_i) begin
          // Abort wins over a simultaneous final idle sample.
          state_d    = ST_ON;
          idle_cnt_d = 8'd0;
        end else if (idle_i) begin
          if (idle_cnt_q == IdleLast) begin
            state_d = ST_OFF;
          end else if (idle_cnt_q != CntMax) begin
            idle_cnt_d = idle_cnt_q + 8'd1;
          end
        end else begin
          // Any busy sample restarts the consecutive-idle run.
          idle_cnt_d = 8'd0;
        end
      end

      ST_OFF: begin
        if (req_en_i) begin
          state_d = ST_WAKE;
        end
      end

      ST_WAKE: begin
        // Clock is already running; hold off ON until the gated domain has settled.
        if (wake_cnt_q == WakeLast) begin
          state_d = ST_ON;
        end else if (wake_cnt_q != CntMax) begin
          wake_cnt_d = wake_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_ON;
      end
    endcase

    if (state_d != state_q) begin
      idle_cnt_d = 8'd0;
      wake_cnt_d = 8'd0;
    end
  end

  // Output decode from next state so the registered outputs track the state register exactly.
  always_comb begin
    en_d     = (state_d != ST_OFF);
    status_d = (state_d == ST_ON);
    busy_d   = (state_d == ST_WAIT_IDLE) || (state_d == ST_WAKE);
  end

  // State and counter registers; reset lands in ON with counters cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_ON;
      idle_cnt_q <= 8'd0;
      wake_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  // Output flops; async reset raises en_o at once even if the FSM was in OFF or WAKE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_o     <= 1'b1;
      status_o <= 1'b1;
      busy_o   <= 1'b0;
    end else begin
      en_o     <= en_d;
      status_o <= status_d;
      busy_o   <= busy_d;
    end
  end

  // Output consistency: gated clock implies neither ON nor transitional, and ON excludes busy.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (en_o || (!status_o && !busy_o));
      assert (!(status_o && busy_o));
    end
  end

endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// Purpose: directed checks of gating, idle glitch, abort race, wake, async reset and re-gate.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next one.
// Backpressure: not applicable.
module tb_prim_clock_gate_ctrl;

  logic clk_i;
  logic rst_ni;
  logic req_en_i;
  logic idle_i;
  logic en_o;
  logic status_o;
  logic busy_o;

  int total;
  int bad;

  prim_clock_gate_ctrl #(
    .IdleCycles(4),
    .WakeCycles(2)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_en_i(req_en_i),
    .idle_i  (idle_i),
    .en_o    (en_o),
    .status_o(status_o),
    .busy_o  (busy_o)
  );

  // 10ns clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // From ON: request off with idle asserted; five edges reach OFF.
  task automatic drive_to_off();
    req_en_i = 1'b0;
    idle_i   = 1'b1;
    repeat (5) step();
  endtask

  // From OFF: request on; three edges reach ON.
  task automatic drive_to_on();
    req_en_i = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_ni   = 1'b0;
    req_en_i = 1'b1;
    idle_i   = 1'b0;
    repeat (2) step();
    total++;
    if (en_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_en got=%b exp=1", en_o);
    end
    total++;
    if (status_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_status got=%b exp=1", status_o);
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b exp=0", busy_o);
    end
    rst_ni = 1'b1;
    step();
    total++;
    if ({en_o, status_o, busy_o} !== 3'b110) begin
      bad++;
      $display("FAIL reset_release_on got=%b exp=110", {en_o, status_o, busy_o});
    end
  endtask

  task automatic test_gate();
    req_en_i = 1'b0;
    idle_i   = 1'b1;
    step();  // edge 0: ON -> WAIT_IDLE
    total++;
    if ({en_o, status_o, busy_o} !== 3'b101) begin
      bad++;
      $display("FAIL gate_wait_entry got=%b exp=101", {en_o, status_o, busy_o});
    end
    for (int e = 1; e <= 3; e++) begin
      step();
      total++;
      if (en_o !== 1'b1) begin
        bad++;
        $display("FAIL gate_early_edge%0d got=%b exp=1", e, en_o);
      end
    end
    step();  // edge 4: enters OFF
    total++;
    if ({en_o, status_o, busy_o} !== 3'b000) begin
      bad++;
      $display("FAIL gate_off got=%b exp=000", {en_o, status_o, busy_o});
    end
    // idle dropping in OFF must not matter
    idle_i = 1'b0;
    step();
    total++;
    if (en_o !== 1'b0) begin
      bad++;
      $display("FAIL gate_off_hold got=%b exp=0", en_o);
    end
  endtask

  task automatic test_wake();
    req_en_i = 1'b1;
    step();  // OFF -> WAKE
    total++;
    if ({en_o, status_o, busy_o} !== 3'b101) begin
      bad++;
      $display("FAIL wake_entry got=%b exp=101", {en_o, status_o, busy_o});
    end
    req_en_i = 1'b0;  // ignored pulse during WAKE
    step();
    total++;
    if ({en_o, status_o, busy_o} !== 3'b101) begin
      bad++;
      $display("FAIL wake_hold got=%b exp=101", {en_o, status_o, busy_o});
    end
    req_en_i = 1'b1;
    step();  // second edge after entry: ON
    total++;
    if ({en_o, status_o, busy_o} !== 3'b110) begin
      bad++;
      $display("FAIL wake_on got=%b exp=110", {en_o, status_o, busy_o});
    end
    step();
    total++;
    if ({en_o, status_o, busy_o} !== 3'b110) begin
      bad++;
      $display("FAIL wake_stay_on got=%b exp=110", {en_o, status_o, busy_o});
    end
  endtask

  task automatic test_idle_glitch();
    logic [0:7] pat;
    logic [0:7] exp_en;
    pat    = 8'b1110_1111;
    exp_en = 8'b1111_1110;
    req_en_i = 1'b0;
    idle_i   = 1'b0;
    step();  // ON -> WAIT_IDLE
    for (int i = 0; i < 8; i++) begin
      idle_i = pat[i];
      step();
      total++;
      if (en_o !== exp_en[i]) begin
        bad++;
        $display("FAIL glitch_sample%0d got=%b exp=%b", i, en_o, exp_en[i]);
      end
    end
    total++;
    if ({status_o, busy_o} !== 2'b00) begin
      bad++;
      $display("FAIL glitch_off_flags got=%b exp=00", {status_o, busy_o});
    end
    drive_to_on();
  endtask

  task automatic test_abort();
    req_en_i = 1'b0;
    idle_i   = 1'b1;
    step();           // WAIT_IDLE, cnt 0
    repeat (3) step();  // cnt 1,2,3
    total++;
    if ({en_o, busy_o} !== 2'b11) begin
      bad++;
      $display("FAIL abort_pre got=%b exp=11", {en_o, busy_o});
    end
    req_en_i = 1'b1;  // same cycle as final idle sample
    step();
    total++;
    if ({en_o, status_o, busy_o} !== 3'b110) begin
      bad++;
      $display("FAIL abort_race got=%b exp=110", {en_o, status_o, busy_o});
    end
    // counter must have cleared: a fresh attempt needs four new idle samples
    req_en_i = 1'b0;
    step();
    repeat (3) step();
    total++;
    if (en_o !== 1'b1) begin
      bad++;
      $display("FAIL abort_cnt_cleared got=%b exp=1", en_o);
    end
    step();
    total++;
    if (en_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_regate got=%b exp=0", en_o);
    end
    drive_to_on();
  endtask

  task automatic test_reset_mid();
    drive_to_off();
    total++;
    if (en_o !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_off got=%b exp=0", en_o);
    end
    #2 rst_ni = 1'b0;  // between edges
    #1;
    total++;
    if ({en_o, status_o, busy_o} !== 3'b110) begin
      bad++;
      $display("FAIL rstmid_async got=%b exp=110", {en_o, status_o, busy_o});
    end
    @(negedge clk_i);
    rst_ni   = 1'b1;
    req_en_i = 1'b1;
    step();
    step();
    total++;
    if ({en_o, status_o, busy_o} !== 3'b110) begin
      bad++;
      $display("FAIL rstmid_stay_on got=%b exp=110", {en_o, status_o, busy_o});
    end
  endtask

  task automatic test_regate();
    drive_to_off();
    req_en_i = 1'b1;
    step();  // WAKE
    req_en_i = 1'b0;
    idle_i   = 1'b1;
    step();  // WAKE (count)
    step();  // ON
    total++;
    if ({en_o, status_o, busy_o} !== 3'b110) begin
      bad++;
      $display("FAIL regate_on_cycle got=%b exp=110", {en_o, status_o, busy_o});
    end
    step();  // WAIT_IDLE
    total++;
    if ({en_o, status_o, busy_o} !== 3'b101) begin
      bad++;
      $display("FAIL regate_wait got=%b exp=101", {en_o, status_o, busy_o});
    end
    repeat (3) step();
    total++;
    if (en_o !== 1'b1) begin
      bad++;
      $display("FAIL regate_early got=%b exp=1", en_o);
    end
    step();
    total++;
    if ({en_o, status_o, busy_o} !== 3'b000) begin
      bad++;
      $display("FAIL regate_off got=%b exp=000", {en_o, status_o, busy_o});
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_ni   = 1'b0;
    req_en_i = 1'b1;
    idle_i   = 1'b0;
    test_reset();
    test_gate();
    test_wake();
    test_idle_glitch();
    test_abort();
    test_reset_mid();
    test_regate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
